img_lk_solver: RTL and testbench

- Hardware 2x2 Lucas-Kanade solve stage, directly downstream of img_lk_acc.
- Consumes one accumulated gradient set (gxx, gyy, gxy, ex, ey) per window.
- Produces fixed-point flow (dx, dy) in the same Q format software writes to the OUT_DX0/OUT_DY0 registers (Q13, i.e. 8192 = 1.0 pixel). Removes the IRQ/software solve round-trip.
- Per-job computation: det = gxx*gyy - gxy^2; dx = (gxy*ey - gyy*ex)*2^Q / det; dy = (gxy*ex - gxx*ey)*2^Q / det.

---
 rtl/img_lk_solver_pkg.sv | 34 +++
 rtl/img_lk_solver_div.sv | 64 ++++++
 rtl/img_lk_solver.sv | 111 +++++++++++
 tb/tb_img_lk_solver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/img_lk_solver_pkg.sv
// Shared widths, types, state codes and the output saturation helper for the
// Lucas-Kanade 2x2 solve stage.
package img_lk_solver_pkg;

    localparam int ACC_W  = 32;
    localparam int OUT_W  = 32;
    localparam int Q_W    = 13;
    localparam int NUM_W  = 2*ACC_W + Q_W + 1;

    typedef logic signed [ACC_W-1:0]   acc_t;
    typedef logic signed [2*ACC_W-1:0] mul_t;
    typedef logic signed [2*ACC_W:0]   prod_t;
    typedef logic signed [OUT_W-1:0]   out_t;
    typedef logic [2:0]                state_t;

    localparam state_t IDLE = 3'd0;
    localparam state_t MUL  = 3'd1;
    localparam state_t NUM  = 3'd2;
    localparam state_t DIV  = 3'd3;
    localparam state_t OUT  = 3'd4;

    localparam out_t OUT_MAX = out_t'((64'sd1 <<< (OUT_W-1)) - 64'sd1);

    // Quotients that do not fit clamp symmetrically, so the most negative code never appears.
    function automatic out_t sat_signed(input logic [NUM_W-1:0] magnitude, input logic sign);
        out_t value;
        if (|magnitude[NUM_W-1:OUT_W-1])
            value = OUT_MAX;
        else
            value = $signed({1'b0, magnitude[OUT_W-2:0]});
        return sign ? -value : value;
    endfunction

endpackage

// File: rtl/img_lk_solver_div.sv
// Unsigned restoring divider, one quotient bit per clock. The start cycle already
// performs the first iteration, so done pulses DIVIDEND_BITS-1 edges after start.
module img_lk_solver_div #(
    parameter int DIVIDEND_BITS = 78,
    parameter int DIVISOR_BITS  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic [DIVIDEND_BITS-1:0] quotient,
    output logic                     done
);

    localparam int CNT_BITS = $clog2(DIVIDEND_BITS);
    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(DIVIDEND_BITS-1);

    logic [DIVISOR_BITS-1:0]  rem, dvs, src_rem, src_dvs;
    logic [DIVIDEND_BITS-1:0] src_quo;
    logic [DIVISOR_BITS:0]    rem_sh, diff;
    logic                     ge, running;
    logic [CNT_BITS-1:0]      cnt;

    always_comb begin
        src_rem = start ? '0 : rem;
        src_quo = start ? dividend : quotient;
        src_dvs = start ? divisor : dvs;
        rem_sh  = {src_rem, src_quo[DIVIDEND_BITS-1]};
        diff    = rem_sh - {1'b0, src_dvs};
        // rem < divisor always holds, so the top bit of diff is a clean borrow flag.
        ge      = ~diff[DIVISOR_BITS];
    end

    always_ff @(posedge clk) begin
        // NOTE: all state updates use <= so every register samples pre-edge values.
        if (reset) begin
            quotient <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || running) begin
                quotient <= {src_quo[DIVIDEND_BITS-2:0], ge};
                rem      <= ge ? diff[DIVISOR_BITS-1:0] : rem_sh[DIVISOR_BITS-1:0];
            end
            if (start) begin
                dvs     <= divisor;
                cnt     <= CNT_BITS'(1);
                running <= 1'b1;
            end else if (running) begin
                cnt <= cnt + CNT_BITS'(1);
                if (cnt == LAST) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/img_lk_solver.sv
// 2x2 Lucas-Kanade solve: products, determinant/numerators, then two lockstep
// dividers produce Q-format flow (dx, dy) with singular-system detection.
module img_lk_solver
    import img_lk_solver_pkg::*;
#(
    parameter int ACC_BITS = ACC_W,
    parameter int OUT_BITS = OUT_W,
    parameter int Q_BITS   = Q_W,
    parameter int DET_MIN  = 0,
    parameter int NUM_BITS = 2*ACC_BITS + Q_BITS + 1
) (
    input  logic clk,
    input  logic reset,
    input  acc_t s_gxx,
    input  acc_t s_gyy,
    input  acc_t s_gxy,
    input  acc_t s_ex,
    input  acc_t s_ey,
    input  logic s_valid,
    output logic s_ready,
    output out_t m_dx,
    output out_t m_dy,
    output logic m_invalid,
    output logic m_valid,
    input  logic m_ready,
    output logic busy
);

    localparam logic [2*ACC_BITS-1:0] DET_LIM = (2*ACC_BITS)'(DET_MIN);

    state_t state;
    acc_t   r_gxx, r_gyy, r_gxy, r_ex, r_ey;
    mul_t   p_xxyy, p_xyxy, p_xyey, p_yyex, p_xyex, p_xxey;
    prod_t  det, numx, numy, abs_x, abs_y;
    logic   singular, neg_x, neg_y, div_start, done_x, done_y;
    logic [NUM_BITS-1:0] dvd_x, dvd_y, q_x, q_y;

    assign s_ready   = (state == IDLE);
    assign m_valid   = (state == OUT);
    assign busy      = (state != IDLE);
    assign div_start = (state == NUM) && !singular;

    always_comb begin
        det      = prod_t'(p_xxyy) - prod_t'(p_xyxy);
        numx     = prod_t'(p_xyey) - prod_t'(p_yyex);
        numy     = prod_t'(p_xyex) - prod_t'(p_xxey);
        abs_x    = numx[2*ACC_BITS] ? -numx : numx;
        abs_y    = numy[2*ACC_BITS] ? -numy : numy;
        dvd_x    = {abs_x, {Q_BITS{1'b0}}};
        dvd_y    = {abs_y, {Q_BITS{1'b0}}};
        singular = det[2*ACC_BITS] || (det[2*ACC_BITS-1:0] <= DET_LIM);
    end

    img_lk_solver_div #(.DIVIDEND_BITS(NUM_BITS), .DIVISOR_BITS(2*ACC_BITS)) u_div_x (
        .clk(clk), .reset(reset), .start(div_start), .dividend(dvd_x),
        .divisor(det[2*ACC_BITS-1:0]), .quotient(q_x), .done(done_x)
    );

    img_lk_solver_div #(.DIVIDEND_BITS(NUM_BITS), .DIVISOR_BITS(2*ACC_BITS)) u_div_y (
        .clk(clk), .reset(reset), .start(div_start), .dividend(dvd_y),
        .divisor(det[2*ACC_BITS-1:0]), .quotient(q_y), .done(done_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            m_dx      <= '0;
            m_dy      <= '0;
            m_invalid <= 1'b0;
            neg_x     <= 1'b0;
            neg_y     <= 1'b0;
            {r_gxx, r_gyy, r_gxy, r_ex, r_ey} <= '0;
            {p_xxyy, p_xyxy, p_xyey, p_yyex, p_xyex, p_xxey} <= '0;
        end else begin
            case (state)
                IDLE: if (s_valid) begin
                    {r_gxx, r_gyy, r_gxy, r_ex, r_ey} <= {s_gxx, s_gyy, s_gxy, s_ex, s_ey};
                    state <= MUL;
                end
                MUL: begin
                    p_xxyy <= mul_t'(r_gxx) * mul_t'(r_gyy);
                    p_xyxy <= mul_t'(r_gxy) * mul_t'(r_gxy);
                    p_xyey <= mul_t'(r_gxy) * mul_t'(r_ey);
                    p_yyex <= mul_t'(r_gyy) * mul_t'(r_ex);
                    p_xyex <= mul_t'(r_gxy) * mul_t'(r_ex);
                    p_xxey <= mul_t'(r_gxx) * mul_t'(r_ey);
                    state  <= NUM;
                end
                NUM: if (singular) begin
                    m_dx      <= '0;
                    m_dy      <= '0;
                    m_invalid <= 1'b1;
                    state     <= OUT;
                end else begin
                    neg_x <= numx[2*ACC_BITS];
                    neg_y <= numy[2*ACC_BITS];
                    state <= DIV;
                end
                DIV: if (done_x && done_y) begin
                    m_dx      <= sat_signed(q_x, neg_x);
                    m_dy      <= sat_signed(q_y, neg_y);
                    m_invalid <= 1'b0;
                    state     <= OUT;
                end
                OUT: if (m_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_lk_solver.sv
// Directed bench for img_lk_solver: a wide-integer reference model plus
// hand-computed literal expectations, compared on every valid output cycle.
module tb_img_lk_solver;
    import img_lk_solver_pkg::*;

    logic clk = 1'b0;
    logic reset, s_valid, s_ready, m_invalid, m_valid, m_ready, busy;
    acc_t s_gxx, s_gyy, s_gxy, s_ex, s_ey;
    out_t m_dx, m_dy;

    localparam longint MAXV = 64'sd2147483647;

    typedef struct {
        longint dx;
        longint dy;
        longint inv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    img_lk_solver dut (
        .clk(clk), .reset(reset),
        .s_gxx(s_gxx), .s_gyy(s_gyy), .s_gxy(s_gxy), .s_ex(s_ex), .s_ey(s_ey),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_dx(m_dx), .m_dy(m_dy), .m_invalid(m_invalid), .m_valid(m_valid),
        .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic longint sat(input logic signed [127:0] v);
        if (v > 128'(MAXV))  return MAXV;
        if (v < -128'(MAXV)) return -MAXV;
        return longint'(v);
    endfunction

    // Solve the 2x2 system directly with wide signed arithmetic; SV division truncates toward zero.
    function automatic exp_t model(input longint gxx, gyy, gxy, ex, ey);
        logic signed [127:0] a, b, c, e, f, det, nx, ny;
        exp_t r;
        a = gxx; b = gyy; c = gxy; e = ex; f = ey;
        det = a*b - c*c;
        nx  = c*f - b*e;
        ny  = c*e - a*f;
        if (det <= 0) begin
            r.dx = 0; r.dy = 0; r.inv = 1;
        end else begin
            r.dx = sat((nx * 8192) / det);
            r.dy = sat((ny * 8192) / det);
            r.inv = 0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", m_valid, 0);
            end else begin
                check("model_dx", m_dx, exp_q[0].dx);
                check("model_dy", m_dy, exp_q[0].dy);
                check("model_invalid", m_invalid, exp_q[0].inv);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && m_valid && m_ready && exp_q.size() > 0) exp_q.pop_front();
    end

    task automatic drive(input longint gxx, gyy, gxy, ex, ey);
        s_gxx = acc_t'(gxx); s_gyy = acc_t'(gyy); s_gxy = acc_t'(gxy);
        s_ex = acc_t'(ex); s_ey = acc_t'(ey);
        s_valid = 1'b1;
    endtask

    // Called at a negedge with s_valid high; returns at the negedge after the accept edge.
    task automatic accept();
        int n = 0;
        while (!s_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", s_ready, 1);
        exp_q.push_back(model(s_gxx, s_gyy, s_gxy, s_ex, s_ey));
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("s_ready_after_accept", s_ready, 0);
    endtask

    // Edge count includes the accept edge itself.
    task automatic wait_out(input int lat, input longint dx, input longint dy, input longint inv);
        int edges = 1;
        while (!m_valid && edges < 300) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", edges, lat);
        check("lit_dx", m_dx, dx);
        check("lit_dy", m_dy, dy);
        check("lit_invalid", m_invalid, inv);
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("valid_drop", m_valid, 0);
    endtask

    task automatic job(input longint gxx, gyy, gxy, ex, ey, input int lat,
                       input longint dx, input longint dy, input longint inv);
        drive(gxx, gyy, gxy, ex, ey);
        accept();
        wait_out(lat, dx, dy, inv);
        consume();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        s_gxx = '0; s_gyy = '0; s_gxy = '0; s_ex = '0; s_ey = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_m_dx", m_dx, 0);
        check("rst_m_dy", m_dy, 0);
        check("rst_m_invalid", m_invalid, 0);

        job(100, 100, 0, -200, 100, 81, 16384, -8192, 0);
        job(3, 3, 0, -1, 1, 81, 2730, -2730, 0);
        job(10, 10, 10, 5, 5, 3, 0, 0, 1);
        job(10, 10, 20, 5, 5, 3, 0, 0, 1);
        job(1, 1, 0, -(64'sd1 <<< 30), 64'sd1 <<< 30, 81, MAXV, -MAXV, 0);
        job(4, 4, 0, 0, 0, 81, 0, 0, 0);
        job(50, 30, 10, 7, -3, 81, -1404, 1287, 0);

        // Back-pressure with a second job waiting on the input.
        drive(100, 100, 0, -200, 100);
        accept();
        wait_out(81, 16384, -8192, 0);
        drive(3, 3, 0, -1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_s_ready", s_ready, 0);
            check("bp_m_valid", m_valid, 1);
            check("bp_hold_dx", m_dx, 16384);
            check("bp_hold_dy", m_dy, -8192);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("bp_valid_drop", m_valid, 0);
        check("bp_s_ready_back", s_ready, 1);
        accept();
        wait_out(81, 2730, -2730, 0);
        consume();

        // Reset in the middle of the division.
        drive(100, 100, 0, -200, 100);
        accept();
        repeat (41) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_m_dx", m_dx, 0);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        job(100, 100, 0, -200, 100, 81, 16384, -8192, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
